// File: rtl/stage_mem.sv
// Memory access stage: issues Wishbone-classic loads/stores, aligns load data, flags faults, registers WB results.
// Optional MEM_TIMEOUT_EN bounds the WAIT state to TIMEOUT_CYCLES before forcing a bus fault.
module stage_mem #(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instruction_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] alu_d_i,
  input  logic [31:0] st_data_i,
  input  logic        e_illegal_inst_i,
  input  logic        e_inst_addr_mis_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic [31:0] dbus_addr_o,
  output logic [31:0] dbus_dat_o,
  output logic [3:0]  dbus_sel_o,
  output logic        dbus_we_o,
  output logic        dbus_cyc_o,
  output logic        dbus_stb_o,
  input  logic [31:0] dbus_dat_i,
  input  logic        dbus_ack_i,
  input  logic        dbus_err_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instruction_o,
  output logic [2:0]  funct3_o,
  output logic [31:0] alu_d_o,
  output logic [31:0] mem_d_o,
  output logic [31:0] mem_addr_o,
  output logic        e_illegal_inst_o,
  output logic        e_inst_addr_mis_o,
  output logic        e_ld_addr_mis_o,
  output logic        e_st_addr_mis_o,
  output logic        e_ld_fault_o,
  output logic        e_st_fault_o
);
  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      r_state, w_next;
  logic        w_is_ld, w_is_st, w_mem, w_legal, w_mis, w_up_exc, w_issue;
  logic        w_timeout, w_done, w_fault, w_in_wait;
  logic        w_capture, w_vld_next;
  logic [3:0]  w_sel;
  logic [31:0] w_wdat, w_lane, w_ld_data;

  assign w_is_ld  = (instruction_i[6:0] == 7'b0000011);
  assign w_is_st  = (instruction_i[6:0] == 7'b0100011);
  assign w_mem    = w_is_ld | w_is_st;
  assign w_legal  = w_is_ld ? !(funct3_i == 3'b011 || funct3_i == 3'b110 || funct3_i == 3'b111) :
                    w_is_st ? (funct3_i[2] == 1'b0 && funct3_i[1:0] != 2'b11) : 1'b1;
  assign w_mis    = ((funct3_i[1:0] == 2'b01) & alu_d_i[0]) |
                    ((funct3_i[1:0] == 2'b10) & (|alu_d_i[1:0]));
  assign w_up_exc = e_illegal_inst_i | e_inst_addr_mis_i;
  assign w_issue  = valid_i & w_mem & w_legal & !w_mis & !w_up_exc & !flush_i;
  assign w_in_wait = (r_state == S_WAIT);
  assign w_fault  = dbus_err_i | w_timeout;
  assign w_done   = dbus_ack_i | w_fault;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] r_tmo_cnt;
  always_ff @(posedge clk_i) begin
    if (rst_i || r_state == S_IDLE) r_tmo_cnt <= 8'd0;
    else                            r_tmo_cnt <= r_tmo_cnt + 8'd1;
  end
  // Fires during the TIMEOUT_CYCLES-th WAIT cycle so the cycle ends on that edge.
  assign w_timeout = w_in_wait && (r_tmo_cnt + 8'd1 == TIMEOUT_CYCLES);
`else
  logic w_unused_tmo;
  assign w_unused_tmo = ^TIMEOUT_CYCLES;
  assign w_timeout    = 1'b0;
`endif

  always_comb begin
    w_sel  = 4'b1111;
    w_wdat = st_data_i;
    case (funct3_i[1:0])
      2'b00: begin w_sel = 4'b0001 << alu_d_i[1:0]; w_wdat = {4{st_data_i[7:0]}};  end
      2'b01: begin w_sel = 4'b0011 << alu_d_i[1:0]; w_wdat = {2{st_data_i[15:0]}}; end
      default: ;
    endcase
  end

  assign w_lane = dbus_dat_i >> {alu_d_i[1:0], 3'b000};
  always_comb begin
    w_ld_data = w_lane;
    case (funct3_i)
      3'b000: w_ld_data = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001: w_ld_data = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100: w_ld_data = {24'd0, w_lane[7:0]};
      3'b101: w_ld_data = {16'd0, w_lane[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_issue) w_next = S_WAIT;
      S_WAIT:  if (flush_i || w_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Flush in WAIT still loads the result register, but valid_o stays low so it is discarded.
  always_comb begin
    stall_o    = 1'b0;
    w_capture  = 1'b0;
    w_vld_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        stall_o    = w_issue;
        w_capture  = !w_issue;
        w_vld_next = valid_i & !flush_i & !w_issue;
      end
      S_WAIT: begin
        stall_o    = !w_done;
        w_capture  = w_done | flush_i;
        w_vld_next = w_done & !flush_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dbus_addr_o <= '0; dbus_dat_o <= '0; dbus_sel_o <= '0;
      dbus_we_o <= 1'b0; dbus_cyc_o <= 1'b0; dbus_stb_o <= 1'b0;
      valid_o <= 1'b0; pc_o <= '0; instruction_o <= '0; funct3_o <= '0;
      alu_d_o <= '0; mem_d_o <= '0; mem_addr_o <= '0;
      e_illegal_inst_o <= 1'b0; e_inst_addr_mis_o <= 1'b0;
      e_ld_addr_mis_o <= 1'b0; e_st_addr_mis_o <= 1'b0;
      e_ld_fault_o <= 1'b0; e_st_fault_o <= 1'b0;
    end else begin
      if (!w_in_wait && w_issue) begin
        dbus_cyc_o  <= 1'b1;
        dbus_stb_o  <= 1'b1;
        dbus_we_o   <= w_is_st;
        dbus_addr_o <= {alu_d_i[31:2], 2'b00};
        dbus_sel_o  <= w_sel;
        dbus_dat_o  <= w_wdat;
      end else if (w_in_wait && (w_done || flush_i)) begin
        dbus_cyc_o <= 1'b0;
        dbus_stb_o <= 1'b0;
        dbus_we_o  <= 1'b0;
      end
      valid_o <= w_vld_next;
      if (w_capture) begin
        pc_o              <= pc_i;
        instruction_o     <= instruction_i;
        funct3_o          <= funct3_i;
        alu_d_o           <= alu_d_i;
        mem_addr_o        <= alu_d_i;
        e_illegal_inst_o  <= e_illegal_inst_i | (w_mem & !w_legal);
        e_inst_addr_mis_o <= e_inst_addr_mis_i;
        e_ld_addr_mis_o   <= w_is_ld & w_legal & w_mis;
        e_st_addr_mis_o   <= w_is_st & w_legal & w_mis;
        e_ld_fault_o      <= w_in_wait & w_is_ld & w_fault;
        e_st_fault_o      <= w_in_wait & w_is_st & w_fault;
        mem_d_o           <= (w_in_wait & w_is_ld & !w_fault) ? w_ld_data : 32'd0;
      end
    end
  end
endmodule

// File: tb/tb_stage_mem.sv
// Bench for stage_mem: directed literal cases then randomized traffic against a transaction-level model.
module tb_stage_mem;
  localparam logic [7:0] TMO = 8'd4;
`ifdef MEM_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk_i = 1'b0, rst_i, valid_i, flush_i;
  logic [31:0] pc_i, instruction_i, alu_d_i, st_data_i, dbus_dat_i;
  logic [2:0]  funct3_i;
  logic        e_illegal_inst_i, e_inst_addr_mis_i, dbus_ack_i, dbus_err_i;
  logic        stall_o, dbus_we_o, dbus_cyc_o, dbus_stb_o, valid_o;
  logic [31:0] dbus_addr_o, dbus_dat_o, pc_o, instruction_o, alu_d_o, mem_d_o, mem_addr_o;
  logic [3:0]  dbus_sel_o;
  logic [2:0]  funct3_o;
  logic        e_illegal_inst_o, e_inst_addr_mis_o, e_ld_addr_mis_o, e_st_addr_mis_o;
  logic        e_ld_fault_o, e_st_fault_o;

  stage_mem #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .pc_i(pc_i), .instruction_i(instruction_i),
    .funct3_i(funct3_i), .alu_d_i(alu_d_i), .st_data_i(st_data_i),
    .e_illegal_inst_i(e_illegal_inst_i), .e_inst_addr_mis_i(e_inst_addr_mis_i), .flush_i(flush_i),
    .stall_o(stall_o), .dbus_addr_o(dbus_addr_o), .dbus_dat_o(dbus_dat_o), .dbus_sel_o(dbus_sel_o),
    .dbus_we_o(dbus_we_o), .dbus_cyc_o(dbus_cyc_o), .dbus_stb_o(dbus_stb_o), .dbus_dat_i(dbus_dat_i),
    .dbus_ack_i(dbus_ack_i), .dbus_err_i(dbus_err_i), .valid_o(valid_o), .pc_o(pc_o),
    .instruction_o(instruction_o), .funct3_o(funct3_o), .alu_d_o(alu_d_o), .mem_d_o(mem_d_o),
    .mem_addr_o(mem_addr_o), .e_illegal_inst_o(e_illegal_inst_o), .e_inst_addr_mis_o(e_inst_addr_mis_o),
    .e_ld_addr_mis_o(e_ld_addr_mis_o), .e_st_addr_mis_o(e_st_addr_mis_o),
    .e_ld_fault_o(e_ld_fault_o), .e_st_fault_o(e_st_fault_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0, fails = 0;
  // model state: a bus transaction is outstanding, and for how many cycles
  bit m_wait = 0, m_init = 0;
  int m_cnt = 0;
  bit x_stall, s_stall;
  bit x_all, x_valid, x_cyc, x_we;
  logic [31:0] x_addr, x_dat, x_pc, x_ins, x_alu, x_memd, x_maddr;
  logic [3:0]  x_sel;
  logic [2:0]  x_f3;
  bit x_ill, x_imis, x_ldmis, x_stmis, x_ldf, x_stf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit legal_f(bit ld, bit st, logic [2:0] f);
    if (ld) return f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    if (st) return f <= 3'd2;
    return 1'b1;
  endfunction

  function automatic logic [31:0] repl(logic [31:0] d, int nb);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % nb) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] load_val(logic [31:0] d, logic [1:0] off, logic [2:0] f);
    int nb;
    logic [31:0] v, mask;
    nb = 1 << f[1:0];
    v = d >> (8 * off);
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
    v = v & mask;
    if (!f[2] && nb < 4 && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  // Inputs are already driven; predict stall now and registered outputs after the next edge.
  task automatic cycle();
    bit ld, st, mem, lg, mis, iss, tmo, done, fault;
    int nb;
    logic [31:0] a;
    logic [7:0] t;
    #1;
    a   = alu_d_i;
    ld  = (instruction_i[6:0] == 7'b0000011);
    st  = (instruction_i[6:0] == 7'b0100011);
    mem = ld | st;
    lg  = legal_f(ld, st, funct3_i);
    nb  = 1 << funct3_i[1:0];
    mis = mem && lg && ((int'(a[1:0]) % nb) != 0);
    iss = valid_i && mem && lg && !mis && !e_illegal_inst_i && !e_inst_addr_mis_i && !flush_i;
    tmo = TMO_EN && m_wait && (m_cnt + 1 == int'(TMO));
    done = m_wait && (dbus_ack_i || dbus_err_i || tmo);
    x_stall = m_wait ? !done : iss;
    if (m_init) chk("stall", stall_o, x_stall);
    s_stall = stall_o;
    x_all = 0;
    if (rst_i) begin
      x_all = 1; x_valid = 0; x_cyc = 0; x_we = 0; x_addr = 0; x_dat = 0; x_sel = 0;
      x_pc = 0; x_ins = 0; x_f3 = 0; x_alu = 0; x_memd = 0; x_maddr = 0;
      x_ill = 0; x_imis = 0; x_ldmis = 0; x_stmis = 0; x_ldf = 0; x_stf = 0;
      m_wait = 0; m_cnt = 0; m_init = 1;
    end else if (!m_wait && iss) begin
      x_cyc = 1; x_we = st; x_valid = 0;
      x_addr = a & ~32'h3;
      t = ((8'd1 << nb) - 8'd1) << a[1:0];
      x_sel = t[3:0];
      x_dat = repl(st_data_i, nb);
      m_wait = 1; m_cnt = 0;
    end else if (m_wait && !(flush_i || done)) begin
      m_cnt++; x_valid = 0;
    end else begin
      fault = m_wait && (dbus_err_i || tmo);
      x_valid = m_wait ? !flush_i : (valid_i && !flush_i);
      x_cyc = 0; x_we = 0;
      x_pc = pc_i; x_ins = instruction_i; x_f3 = funct3_i; x_alu = a; x_maddr = a;
      x_ill = e_illegal_inst_i || (mem && !lg); x_imis = e_inst_addr_mis_i;
      x_ldmis = ld && mis; x_stmis = st && mis;
      x_ldf = ld && fault; x_stf = st && fault;
      x_memd = (m_wait && ld && !fault) ? load_val(dbus_dat_i, a[1:0], funct3_i) : 32'd0;
      m_wait = 0;
    end
    @(posedge clk_i); #1;
    chk("valid_o", valid_o, x_valid);
    chk("cyc", dbus_cyc_o, x_cyc);
    chk("stb", dbus_stb_o, x_cyc);
    chk("we", dbus_we_o, x_we);
    if (x_cyc || x_all) begin
      chk("addr", dbus_addr_o, x_addr);
      chk("sel", dbus_sel_o, x_sel);
      chk("dat_o", dbus_dat_o, x_dat);
    end
    if (x_valid || x_all) begin
      chk("pc_o", pc_o, x_pc);            chk("instr_o", instruction_o, x_ins);
      chk("funct3_o", funct3_o, x_f3);    chk("alu_d_o", alu_d_o, x_alu);
      chk("mem_d_o", mem_d_o, x_memd);    chk("mem_addr_o", mem_addr_o, x_maddr);
      chk("e_ill", e_illegal_inst_o, x_ill);   chk("e_imis", e_inst_addr_mis_o, x_imis);
      chk("e_ldmis", e_ld_addr_mis_o, x_ldmis); chk("e_stmis", e_st_addr_mis_o, x_stmis);
      chk("e_ldf", e_ld_fault_o, x_ldf);       chk("e_stf", e_st_fault_o, x_stf);
    end
    @(negedge clk_i);
  endtask

  task automatic set_op(input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd);
    valid_i = 1; instruction_i = {17'h0, f3, 5'd1, op}; funct3_i = f3;
    alu_d_i = a; st_data_i = sd; pc_i = 32'h0000_1000;
    e_illegal_inst_i = 0; e_inst_addr_mis_i = 0; flush_i = 0; dbus_ack_i = 0; dbus_err_i = 0;
  endtask

  task automatic idle();
    valid_i = 0; flush_i = 0; dbus_ack_i = 0; dbus_err_i = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int nst;
    bit hold, p_flush, p_rst;
    logic [31:0] rr;
    int r;
    rst_i = 1; valid_i = 0; flush_i = 0; pc_i = 0; instruction_i = 0; funct3_i = 0;
    alu_d_i = 0; st_data_i = 0; dbus_dat_i = 0; dbus_ack_i = 0; dbus_err_i = 0;
    e_illegal_inst_i = 0; e_inst_addr_mis_i = 0;
    cycle(); cycle();
    chk("rst_valid", valid_o, 0); chk("rst_cyc", dbus_cyc_o, 0); chk("rst_memd", mem_d_o, 0);
    rst_i = 0;

    // LB 0x103 -> lane 3, sign-extended 0x80
    set_op(7'b0000011, 3'b000, 32'h103, 0); cycle();
    chk("t1_sel", dbus_sel_o, 4'b1000); chk("t1_addr", dbus_addr_o, 32'h100); chk("t1_v0", valid_o, 0);
    dbus_ack_i = 1; dbus_dat_i = 32'h80FF_FF7F; cycle();
    chk("t1_memd", mem_d_o, 32'hFFFF_FF80); chk("t1_v", valid_o, 1);
    idle(); cycle();

    set_op(7'b0100011, 3'b001, 32'h202, 32'h0000_BEEF); cycle();
    chk("t2_dat", dbus_dat_o, 32'hBEEF_BEEF); chk("t2_sel", dbus_sel_o, 4'b1100); chk("t2_we", dbus_we_o, 1);
    dbus_ack_i = 1; cycle();
    chk("t2_stf", e_st_fault_o, 0); chk("t2_stmis", e_st_addr_mis_o, 0); chk("t2_v", valid_o, 1);
    idle(); cycle();

    set_op(7'b0000011, 3'b010, 32'h101, 0); cycle();
    chk("t3_cyc", dbus_cyc_o, 0); chk("t3_mis", e_ld_addr_mis_o, 1);
    chk("t3_maddr", mem_addr_o, 32'h101); chk("t3_v", valid_o, 1);
    idle(); cycle();

    set_op(7'b0000011, 3'b010, 32'h100, 0); dbus_dat_i = 32'h1234_5678; nst = 0;
    for (int k = 0; k < 5; k++) begin dbus_ack_i = (k == 4); cycle(); nst += s_stall; end
    chk("t4_stall", nst, 4); chk("t4_cyc", dbus_cyc_o, 0); chk("t4_v", valid_o, 1);
    chk("t4_memd", mem_d_o, 32'h1234_5678);
    idle(); cycle();

    set_op(7'b0000011, 3'b010, 32'h104, 0); cycle(); cycle();
    flush_i = 1; cycle();
    chk("t5_cyc", dbus_cyc_o, 0); chk("t5_stb", dbus_stb_o, 0); chk("t5_v", valid_o, 0);
    idle(); dbus_ack_i = 1; cycle();
    chk("t5_late", valid_o, 0);
    idle(); cycle();

`ifdef MEM_TIMEOUT_EN
    set_op(7'b0100011, 3'b010, 32'h300, 32'h55); cycle();
    for (int k = 0; k < 4; k++) cycle();
    chk("t6_stf", e_st_fault_o, 1); chk("t6_cyc", dbus_cyc_o, 0); chk("t6_v", valid_o, 1);
    idle(); cycle();
`endif

    p_flush = 0; p_rst = 0;
    for (int n = 0; n < 3000; n++) begin
      hold = x_stall && !p_flush && !p_rst;
      if (!hold) begin
        rr = $urandom(); r = $urandom_range(0, 9);
        valid_i = ($urandom_range(0, 9) != 0);
        funct3_i = 3'($urandom_range(0, 7));
        instruction_i = {rr[31:15], funct3_i, rr[11:7],
                         (r < 4) ? 7'b0000011 : (r < 8) ? 7'b0100011 : (r == 8) ? 7'b0110011 : 7'b0010011};
        alu_d_i = $urandom();
        if ($urandom_range(0, 1) == 0) alu_d_i[1:0] = 2'b00;
        pc_i = $urandom(); st_data_i = $urandom();
        e_illegal_inst_i = ($urandom_range(0, 15) == 0);
        e_inst_addr_mis_i = ($urandom_range(0, 15) == 0);
      end
      flush_i = ($urandom_range(0, 11) == 0);
      rst_i = ($urandom_range(0, 199) == 0);
      dbus_dat_i = $urandom();
      r = $urandom_range(0, 7);
      dbus_ack_i = m_wait ? (r < 3) : (r == 0);
      dbus_err_i = m_wait && (r == 3);
      p_flush = flush_i; p_rst = rst_i;
      cycle();
    end
    rst_i = 0; idle(); cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
